// File: rtl/vga_timing_pkg.sv
// Shared timing types, standard mode presets and helpers for the VGA timing generator.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } video_timing_t;

  localparam video_timing_t SVGA_800x600_60 = '{
    h: '{active: 800, front: 40, sync: 128, back: 88},
    v: '{active: 600, front: 1,  sync: 4,   back: 23}
  };

  localparam video_timing_t VGA_640x480_60 = '{
    h: '{active: 640, front: 16, sync: 96, back: 48},
    v: '{active: 480, front: 10, sync: 2,  back: 33}
  };

  function automatic int unsigned timing_total(input axis_timing_t t);
    return t.active + t.front + t.sync + t.back;
  endfunction

endpackage

// File: rtl/ff_chain.sv
// Enable-gated shift chain of Depth registers; Depth=0 degenerates to a wire.
module ff_chain #(
  parameter int unsigned      Width    = 1,
  parameter int unsigned      Depth    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth == 0) begin : gen_bypass
    assign q_o = d_i;
  end else begin : gen_chain
    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < Depth; i++) stage_q[i] <= ResetVal;
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int unsigned i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing_generator.sv
// Programmable video timing generator with pixel replication, pix_ce gating and
// sync delay to line h_sync/v_sync up with the framebuffer + palette read latency.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FRONT    = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BACK     = 88,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned V_FRONT    = 1,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BACK     = 23,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1,
  parameter int unsigned SCALE      = 2,
  parameter int unsigned SYNC_DELAY = 3,
  parameter int unsigned IDX_W      = $clog2((H_ACTIVE / SCALE) * (V_ACTIVE / SCALE))
) (
  input  logic             clk_i,
  input  logic             aresetn_i,
  input  logic             pix_ce_i,
  output logic [IDX_W-1:0] pixel_index_o,
  output logic             pixel_index_valid_o,
  output logic             h_sync_o,
  output logic             v_sync_o,
  output logic             frame_start_o,
  output logic             line_start_o,
  output logic             vblank_o
);

  localparam axis_timing_t HTiming = '{active: H_ACTIVE, front: H_FRONT, sync: H_SYNC,
                                       back: H_BACK};
  localparam axis_timing_t VTiming = '{active: V_ACTIVE, front: V_FRONT, sync: V_SYNC,
                                       back: V_BACK};
  localparam int unsigned HTot = timing_total(HTiming);
  localparam int unsigned VTot = timing_total(VTiming);
  localparam int unsigned HW   = (HTot > 1) ? $clog2(HTot) : 1;
  localparam int unsigned VW   = (VTot > 1) ? $clog2(VTot) : 1;
  localparam int unsigned SW   = (SCALE > 1) ? $clog2(SCALE) : 1;
  // One spare bit: row_base and col may step one past the last visible value.
  localparam int unsigned CW   = IDX_W + 1;
  localparam int unsigned FbW  = H_ACTIVE / SCALE;

  localparam logic [HW-1:0] HLast = HW'(HTot - 1);
  localparam logic [HW-1:0] HAct  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HsBeg = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HsEnd = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] VLast = VW'(VTot - 1);
  localparam logic [VW-1:0] VAct  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VsBeg = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VsEnd = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [SW-1:0] ScLast = SW'(SCALE - 1);
  localparam logic [CW-1:0] FbWc   = CW'(FbW);

  if (SCALE < 1) begin : gen_bad_scale
    $error("SCALE must be at least 1");
  end
  if ((SCALE >= 1) && ((H_ACTIVE % SCALE != 0) || (V_ACTIVE % SCALE != 0))) begin : gen_bad_div
    $error("H_ACTIVE and V_ACTIVE must be multiples of SCALE");
  end
  if ((H_FRONT == 0) || (H_SYNC == 0) || (H_BACK == 0) ||
      (V_FRONT == 0) || (V_SYNC == 0) || (V_BACK == 0)) begin : gen_bad_porch
    $error("porch and sync widths must be non-zero");
  end

  // Position counters and incremental index state for the current (h,v).
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [SW-1:0] cs_q, cs_d, rs_q, rs_d;
  logic [CW-1:0] col_q, col_d, row_base_q, row_base_d;

  // Registered outputs describing the position just consumed.
  logic [IDX_W-1:0] pixel_index_q, pixel_index_d;
  logic             valid_q, valid_d;
  logic             vblank_q, vblank_d;
  logic             frame_start_q, frame_start_d;
  logic             line_start_q, line_start_d;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic [1:0]       sync_dly;

  always_comb begin
    h_d        = h_q;
    v_d        = v_q;
    cs_d       = cs_q;
    rs_d       = rs_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    if (pix_ce_i) begin
      if (h_q == HLast) begin
        h_d   = '0;
        cs_d  = '0;
        col_d = '0;
        if (v_q == VLast) begin
          v_d        = '0;
          rs_d       = '0;
          row_base_d = '0;
        end else begin
          v_d = v_q + 1'b1;
          if (v_q < VAct) begin
            if (rs_q == ScLast) begin
              rs_d       = '0;
              row_base_d = row_base_q + FbWc;
            end else begin
              rs_d = rs_q + 1'b1;
            end
          end
        end
      end else begin
        h_d = h_q + 1'b1;
        if (h_q < HAct) begin
          if (cs_q == ScLast) begin
            cs_d  = '0;
            col_d = col_q + 1'b1;
          end else begin
            cs_d = cs_q + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    pixel_index_d = pixel_index_q;
    valid_d       = valid_q;
    vblank_d      = vblank_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    frame_start_d = 1'b0;
    line_start_d  = 1'b0;
    if (pix_ce_i) begin
      valid_d       = (h_q < HAct) && (v_q < VAct);
      pixel_index_d = valid_d ? IDX_W'(row_base_q + col_q) : '0;
      vblank_d      = (v_q >= VAct);
      hs_d          = ~(((h_q >= HsBeg) && (h_q < HsEnd)) ^ HS_POL);
      vs_d          = ~(((v_q >= VsBeg) && (v_q < VsEnd)) ^ VS_POL);
      frame_start_d = (h_q == '0) && (v_q == '0);
      line_start_d  = (h_q == '0);
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      h_q           <= '0;
      v_q           <= '0;
      cs_q          <= '0;
      rs_q          <= '0;
      col_q         <= '0;
      row_base_q    <= '0;
      pixel_index_q <= '0;
      valid_q       <= 1'b0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      cs_q          <= cs_d;
      rs_q          <= rs_d;
      col_q         <= col_d;
      row_base_q    <= row_base_d;
      pixel_index_q <= pixel_index_d;
      valid_q       <= valid_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
    end
  end

  ff_chain #(
    .Width    (2),
    .Depth    (SYNC_DELAY),
    .ResetVal ({~VS_POL, ~HS_POL})
  ) u_sync_dly (
    .clk_i  (clk_i),
    .rst_ni (aresetn_i),
    .en_i   (pix_ce_i),
    .d_i    ({vs_q, hs_q}),
    .q_o    (sync_dly)
  );

  assign pixel_index_o       = pixel_index_q;
  assign pixel_index_valid_o = valid_q;
  assign vblank_o            = vblank_q;
  assign frame_start_o       = frame_start_q;
  assign line_start_o        = line_start_q;
  assign h_sync_o            = sync_dly[0];
  assign v_sync_o            = sync_dly[1];

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator on a 14x8 total raster, SCALE=2, SYNC_DELAY=3.
module tb_vga_timing_generator;

  localparam int unsigned IW = 3;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          pix_ce = 1'b0;
  logic [IW-1:0] idx, idx_n;
  logic          valid, hs, vs, fs, ls, vb;
  logic          valid_n, hs_n, vs_n, fs_n, ls_n, vb_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_timing_generator #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .SCALE(2), .SYNC_DELAY(3)
  ) dut (
    .clk_i(clk), .aresetn_i(aresetn), .pix_ce_i(pix_ce),
    .pixel_index_o(idx), .pixel_index_valid_o(valid), .h_sync_o(hs), .v_sync_o(vs),
    .frame_start_o(fs), .line_start_o(ls), .vblank_o(vb)
  );

  vga_timing_generator #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .SCALE(2), .SYNC_DELAY(3)
  ) dut_n (
    .clk_i(clk), .aresetn_i(aresetn), .pix_ce_i(pix_ce),
    .pixel_index_o(idx_n), .pixel_index_valid_o(valid_n), .h_sync_o(hs_n), .v_sync_o(vs_n),
    .frame_start_o(fs_n), .line_start_o(ls_n), .vblank_o(vb_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " idx"}, idx, 0);
    chk({tag, " valid"}, valid, 0);
    chk({tag, " fs"}, fs, 0);
    chk({tag, " ls"}, ls, 0);
    chk({tag, " vblank"}, vb, 0);
    chk({tag, " hs"}, hs, 0);
    chk({tag, " vs"}, vs, 0);
    chk({tag, " hs_n"}, hs_n, 1);
    chk({tag, " vs_n"}, vs_n, 1);
  endtask

  // Expected outputs after the edge that reported position number p of the frame stream.
  task automatic check_pos(input int p, input bit ce_edge);
    int h, v, q, e_idx;
    bit e_val, e_fs, e_ls, e_vb, e_hs, e_vs;
    string t;
    h     = p % 14;
    v     = (p / 14) % 8;
    e_val = (h < 8) && (v < 4);
    e_idx = e_val ? (v / 2) * 4 + h / 2 : 0;
    e_fs  = ce_edge && (h == 0) && (v == 0);
    e_ls  = ce_edge && (h == 0);
    e_vb  = (v >= 4);
    e_hs  = 1'b0;
    e_vs  = 1'b0;
    if (p >= 3) begin
      q    = p - 3;
      e_hs = ((q % 14) >= 10) && ((q % 14) < 13);
      e_vs = (((q / 14) % 8) >= 5) && (((q / 14) % 8) < 7);
    end
    t = $sformatf("p=%0d h=%0d v=%0d", p, h, v);
    chk({t, " idx"}, idx, e_idx);
    chk({t, " valid"}, valid, e_val);
    chk({t, " fs"}, fs, e_fs);
    chk({t, " ls"}, ls, e_ls);
    chk({t, " vblank"}, vb, e_vb);
    chk({t, " hs"}, hs, e_hs);
    chk({t, " vs"}, vs, e_vs);
    chk({t, " hs_n"}, hs_n, !e_hs);
    chk({t, " vs_n"}, vs_n, !e_vs);
    chk({t, " idx_n"}, idx_n, e_idx);
    chk({t, " valid_n"}, valid_n, e_val);
    chk({t, " fs_n"}, fs_n, e_fs);
    chk({t, " ls_n"}, ls_n, e_ls);
    chk({t, " vblank_n"}, vb_n, e_vb);
  endtask

  int  first_idx [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  bit  first_val [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
  int  k;
  bit  ce;

  initial begin
    // Reset state
    aresetn = 1'b0;
    pix_ce  = 1'b1;
    tick();
    tick();
    tick();
    check_reset("reset");

    // Two full frames with pix_ce held high
    aresetn = 1'b1;
    for (int p = 0; p < 2 * 112 + 20; p++) begin
      tick();
      check_pos(p, 1'b1);
      if (p < 9) begin
        chk($sformatf("first line idx h=%0d", p), idx, first_idx[p]);
        chk($sformatf("first line valid h=%0d", p), valid, first_val[p]);
      end
      if (p == 0 || p == 112 || p == 224) chk($sformatf("frame_start p=%0d", p), fs, 1);
      if (p == 12) chk("hs before rise", hs, 0);
      if (p == 13) chk("hs rise", hs, 1);
      if (p == 16) chk("hs fall", hs, 0);
      if (p == 56) chk("vblank line 4", vb, 1);
      if (p == 42) chk("idx line 3", idx, 4);
    end

    // pix_ce pattern 1,0,0,1
    aresetn = 1'b0;
    tick();
    tick();
    check_reset("reset2");
    aresetn = 1'b1;
    k = 0;
    for (int c = 0; c < 480; c++) begin
      ce     = ((c % 4) == 0) || ((c % 4) == 3);
      pix_ce = ce;
      tick();
      if (ce) k++;
      check_pos(k - 1, ce);
    end

    // Asynchronous reset in the middle of a frame at h=5, v=2
    pix_ce  = 1'b1;
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    for (int p = 0; p <= 33; p++) begin
      tick();
      check_pos(p, 1'b1);
    end
    chk("pre-abort idx", idx, 6);
    aresetn = 1'b0;
    #1;
    check_reset("async reset");
    tick();
    tick();
    aresetn = 1'b1;
    for (int p = 0; p < 6; p++) begin
      tick();
      check_pos(p, 1'b1);
      if (p == 0) chk("restart frame_start", fs, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Parametrised successor to the fixed 400x300 VGA controller: a programmable video timing generator with integer pixel-replication scaling, selectable sync polarity, a pixel clock-enable and built-in sync alignment delay.
- Sits in the vga_clk domain, ahead of the framebuffer read and colour palette.
- Emits the framebuffer pixel index, active-video qualifier, syncs already delayed to match downstream read latency, and frame/line/vblank status for the display processor.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FRONT, 40, horizontal front porch (pixels)
H_SYNC, 128, horizontal sync width (pixels)
H_BACK, 88, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FRONT, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_BACK, 23, vertical back porch (lines)
HS_POL, 1, h_sync active level
VS_POL, 1, v_sync active level
SCALE, 2, replication factor in both axes; framebuffer is (H_ACTIVE/SCALE)x(V_ACTIVE/SCALE)
SYNC_DELAY, 3, extra pixel-enabled cycles applied to h_sync/v_sync beyond pixel_index (framebuffer + palette latency)
IDX_W, $clog2((H_ACTIVE/SCALE)*(V_ACTIVE/SCALE)), pixel_index width (derived, do not override)

Ports:
clk  in  1  video clock
aresetn  in  1  asynchronous active-low reset
pix_ce  in  1  pixel clock enable; all timing advances only on clk edges with pix_ce=1
pixel_index  out  IDX_W  framebuffer address (row*FB_W + col) of the current pixel
pixel_index_valid  out  1  current position is in active video
h_sync  out  1  horizontal sync, HS_POL active, delayed by SYNC_DELAY
v_sync  out  1  vertical sync, VS_POL active, delayed by SYNC_DELAY
frame_start  out  1  one-clk pulse at position (0,0)
line_start  out  1  one-clk pulse at h=0 on every line, including blanking lines
vblank  out  1  level, high while v >= V_ACTIVE

Behaviour:
- Totals: H_TOT=H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOT likewise.
- FB_W=H_ACTIVE/SCALE.
- Counters: h in 0..H_TOT-1, v in 0..V_TOT-1.
  - On a pix_ce edge h increments.
  - At h=H_TOT-1, h wraps to 0 and v increments.
  - At (H_TOT-1, V_TOT-1) both wrap to 0.
- Index generation is incremental; no multiplier.
  - Column sub-counter cs in 0..SCALE-1; col increments when cs wraps, only while h<H_ACTIVE.
  - Row sub-counter rs in 0..SCALE-1; row_base += FB_W when rs wraps at end of line, only while v<V_ACTIVE.
  - row_base, col, cs and rs all clear at frame wrap. col and cs clear at every line wrap.
- pixel_index = row_base + col. Drive 0 when not valid.
- Latency:
  - pixel_index, pixel_index_valid, vblank, frame_start and line_start are registered and describe the position (h,v) one pix_ce cycle after it.
  - h_sync/v_sync are registered the same way, then pass through a SYNC_DELAY-stage pix_ce-gated shift chain. SYNC_DELAY=0 means no chain.
- Active and sync regions:
  - valid = (h<H_ACTIVE) and (v<V_ACTIVE).
  - hs_raw = H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC.
  - vs_raw uses the same rule on v.
  - The output level is XNOR of the raw signal with the polarity parameter.
- Pulses: frame_start and line_start assert for exactly one clk cycle following the qualifying pix_ce edge, then clear on the next clk edge regardless of pix_ce.
- pix_ce low: counters, index, valid, vblank and the sync chain all hold their values; pulses clear.
- Reset (asynchronous assert, synchronous deassert handled externally): clears counters and index state.
  - Output reset values: pixel_index=0, valid=0, frame_start=0, line_start=0, vblank=0.
  - h_sync=!HS_POL and v_sync=!VS_POL; every sync chain stage resets to the inactive level.
  - Reset asserted mid-frame aborts the frame. The first pix_ce edge after release reports (0,0) with frame_start=1.
- Elaboration checks: $error if H_ACTIVE%SCALE!=0, V_ACTIVE%SCALE!=0, SCALE<1, or any porch/sync width is 0.

Decomposition:
- Package vga_timing_pkg holds:
  - a timing struct typedef (active/front/sync/back per axis);
  - localparam presets SVGA_800x600_60 and VGA_640x480_60;
  - function timing_total().
- One sub-module: reuse the existing ff_chain for the sync delay, fed by a pix_ce-gated register stage. No other sub-modules.

Test Plan:
All directed tests use small parameters: H=8/2/3/1 (H_TOT=14), V=4/1/2/1 (V_TOT=8), SCALE=2, SYNC_DELAY=3, pix_ce tied 1 unless stated.
1. Release reset -> first cycle: valid=1, index=0, frame_start=1, line_start=1. Index sequence over h=0..7 is 0,0,1,1,2,2,3,3; at h=8 valid=0 and index=0.
2. Full frame -> lines v=0,1 give index 0..3; v=2,3 give 4..7. vblank=1 on v=4..7. frame_start recurs every 112 cycles.
3. h_sync checked -> low (HS_POL=1) except h=10..12. Rising edge appears 3 cycles after the cycle whose outputs report h=10. v_sync high for v=5..6.
4. HS_POL=0, VS_POL=0 -> all sync waveforms inverted. Reset level is 1 on both.
5. pix_ce toggled 1,0,0,1 repeatedly -> output sequence identical to test 1 with each value held through the ce-low cycles. frame_start is high for one clk only.
6. Assert aresetn low at h=5, v=2 for 2 cycles, then release -> outputs go to reset values immediately (asynchronously). Next edge reports index 0 with frame_start=1. The sync chain holds the inactive level for 3 cycles.
